// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter (double dabble, one bit per clock) with
// valid/ready on both sides, optional signed input, overflow and leading-zero mask.
module bin2bcd_stream #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 1
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    I_VALID,
  output logic                    O_READY,
  input  logic [BIN_W-1:0]        I_BIN,
  output logic                    O_VALID,
  input  logic                    I_READY,
  output logic [4*BCD_DIGITS-1:0] O_BCD,
  output logic                    O_NEG,
  output logic                    O_OVF,
  output logic [BCD_DIGITS-1:0]   O_BLANK,
  output logic                    O_BUSY
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;
  logic             neg_r;

  logic             in_neg;
  logic [BIN_W-1:0] in_mag;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] all_nines;
  logic [BCD_W-1:0] fin_bcd;
  logic [BCD_DIGITS-1:0] fin_blank;
  logic             all_zero;

  // The most negative input still has a representable unsigned magnitude.
  always_comb begin
    in_neg = (SIGNED != 0) && I_BIN[BIN_W-1];
    in_mag = in_neg ? (~I_BIN + {{(BIN_W-1){1'b0}}, 1'b1}) : I_BIN;
  end

  always_comb begin
    bcd_adj   = bcd_sr;
    all_nines = '0;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
      all_nines[4*k +: 4] = 4'd9;
    end
  end

  // Saturated results contain no zero digits, so blanking falls out as all-zero.
  always_comb begin
    fin_bcd   = ((SATURATE != 0) && ovf_sticky) ? all_nines : bcd_sr;
    fin_blank = '0;
    all_zero  = 1'b1;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      all_zero     = all_zero && (fin_bcd[4*k +: 4] == 4'd0);
      fin_blank[k] = all_zero;
    end
  end

  assign O_READY = (state == IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      neg_r      <= 1'b0;
      O_VALID    <= 1'b0;
      O_BUSY     <= 1'b0;
      O_BCD      <= '0;
      O_NEG      <= 1'b0;
      O_OVF      <= 1'b0;
      O_BLANK    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_VALID) begin
            bin_sr     <= in_mag;
            bcd_sr     <= '0;
            ovf_sticky <= 1'b0;
            neg_r      <= in_neg;
            cnt        <= CNT_W'(BIN_W);
            O_BUSY     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Any carry out of the top digit is a multiple of 10^BCD_DIGITS lost.
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          ovf_sticky       <= ovf_sticky | bcd_adj[BCD_W-1];
          cnt              <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FIN;
        end
        FIN: begin
          O_BCD   <= fin_bcd;
          O_OVF   <= ovf_sticky;
          O_NEG   <= neg_r;
          O_BLANK <= fin_blank;
          O_VALID <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (I_READY) begin
            O_VALID <= 1'b0;
            O_BUSY  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Self-checking bench: four converter variants share one stimulus stream and are
// checked against an arithmetic reference model through a scoreboard queue.
module tb_bin2bcd_stream;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    logic [4:0]  blank;
  } exp_t;

  typedef logic [3:0][26:0] word_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        I_VALID = 1'b0;
  logic        I_READY = 1'b0;
  logic [15:0] I_BIN = '0;

  wire [3:0]  rdy, vld, neg, ovf, busy;
  wire [19:0] bcd_a, bcd_b;
  wire [15:0] bcd_c, bcd_d;
  wire [4:0]  blank_a, blank_b;
  wire [3:0]  blank_c, blank_d;

  int    checks = 0;
  int    failures = 0;
  word_t scoreboard[$];

  always #5 CLK = ~CLK;

  bin2bcd_stream #(.BIN_W(16), .BCD_DIGITS(5), .SIGNED(0), .SATURATE(1)) u_a (
    .CLK(CLK), .RST_n(RST_n), .I_VALID(I_VALID), .O_READY(rdy[0]), .I_BIN(I_BIN),
    .O_VALID(vld[0]), .I_READY(I_READY), .O_BCD(bcd_a), .O_NEG(neg[0]), .O_OVF(ovf[0]),
    .O_BLANK(blank_a), .O_BUSY(busy[0]));
  bin2bcd_stream #(.BIN_W(16), .BCD_DIGITS(5), .SIGNED(1), .SATURATE(1)) u_b (
    .CLK(CLK), .RST_n(RST_n), .I_VALID(I_VALID), .O_READY(rdy[1]), .I_BIN(I_BIN),
    .O_VALID(vld[1]), .I_READY(I_READY), .O_BCD(bcd_b), .O_NEG(neg[1]), .O_OVF(ovf[1]),
    .O_BLANK(blank_b), .O_BUSY(busy[1]));
  bin2bcd_stream #(.BIN_W(16), .BCD_DIGITS(4), .SIGNED(0), .SATURATE(1)) u_c (
    .CLK(CLK), .RST_n(RST_n), .I_VALID(I_VALID), .O_READY(rdy[2]), .I_BIN(I_BIN),
    .O_VALID(vld[2]), .I_READY(I_READY), .O_BCD(bcd_c), .O_NEG(neg[2]), .O_OVF(ovf[2]),
    .O_BLANK(blank_c), .O_BUSY(busy[2]));
  bin2bcd_stream #(.BIN_W(16), .BCD_DIGITS(4), .SIGNED(0), .SATURATE(0)) u_d (
    .CLK(CLK), .RST_n(RST_n), .I_VALID(I_VALID), .O_READY(rdy[3]), .I_BIN(I_BIN),
    .O_VALID(vld[3]), .I_READY(I_READY), .O_BCD(bcd_d), .O_NEG(neg[3]), .O_OVF(ovf[3]),
    .O_BLANK(blank_d), .O_BUSY(busy[3]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: digits come from division, not from a shift-and-add model.
  function automatic exp_t model(input logic [15:0] v, input int digits, input bit sgn, input bit sat);
    exp_t e;
    int   mag, limit, t, d;
    bit   allz;
    e     = '0;
    e.neg = sgn && v[15];
    mag   = e.neg ? (65536 - int'(v)) : int'(v);
    limit = 1;
    for (int k = 0; k < digits; k++) limit = limit * 10;
    e.ovf = (mag >= limit);
    t = mag % limit;
    for (int k = 0; k < digits; k++) begin
      d = (e.ovf && sat) ? 9 : (t % 10);
      t = t / 10;
      e.bcd[4*k +: 4] = 4'(d);
    end
    allz = 1'b1;
    for (int k = digits - 1; k >= 1; k--) begin
      allz = allz && (e.bcd[4*k +: 4] == 4'd0);
      e.blank[k] = allz;
    end
    return e;
  endfunction

  function automatic word_t predict(input logic [15:0] v);
    word_t w;
    w[0] = model(v, 5, 1'b0, 1'b1);
    w[1] = model(v, 5, 1'b1, 1'b1);
    w[2] = model(v, 4, 1'b0, 1'b1);
    w[3] = model(v, 4, 1'b0, 1'b0);
    return w;
  endfunction

  function automatic logic [31:0] obsBcd(input int i);
    case (i)
      0:       return {12'b0, bcd_a};
      1:       return {12'b0, bcd_b};
      2:       return {16'b0, bcd_c};
      default: return {16'b0, bcd_d};
    endcase
  endfunction

  function automatic logic [31:0] obsBlank(input int i);
    case (i)
      0:       return {27'b0, blank_a};
      1:       return {27'b0, blank_b};
      2:       return {28'b0, blank_c};
      default: return {28'b0, blank_d};
    endcase
  endfunction

  task automatic compareResult(input string phase, input word_t w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = w[i];
      checkOutput($sformatf("%s bcd%0d", phase, i), obsBcd(i), 32'(e.bcd));
      checkOutput($sformatf("%s neg%0d", phase, i), 32'(neg[i]), 32'(e.neg));
      checkOutput($sformatf("%s ovf%0d", phase, i), 32'(ovf[i]), 32'(e.ovf));
      checkOutput($sformatf("%s blank%0d", phase, i), obsBlank(i), 32'(e.blank));
    end
  endtask

  // Accept one word, wait for the result, optionally hold it under backpressure, then handshake.
  task automatic applyStimulus(input logic [15:0] v, input int hold);
    int    cyc;
    word_t w;
    @(negedge CLK);
    checkOutput("ready_before_accept", 32'(rdy), 32'hF);
    I_VALID = 1'b1;
    I_BIN   = v;
    scoreboard.push_back(predict(v));
    @(negedge CLK);
    I_VALID = 1'b0;
    I_BIN   = 16'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'hF);
    cyc = 0;
    while (vld != 4'hF && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'd17);
    w = scoreboard.pop_front();
    compareResult("done", w);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      I_VALID = 1'b1;
      I_BIN   = 16'($urandom);
      checkOutput("ready_in_done", 32'(rdy), 32'h0);
      checkOutput("valid_held", 32'(vld), 32'hF);
      compareResult("held", w);
    end
    @(negedge CLK);
    I_VALID = 1'b1;
    I_READY = 1'b1;
    @(negedge CLK);
    I_READY = 1'b0;
    checkOutput("valid_after_hs", 32'(vld), 32'h0);
    checkOutput("busy_after_hs", 32'(busy), 32'h0);
    I_VALID = 1'b0;
    compareResult("after_hs", w);
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, " ready"}, 32'(rdy), 32'hF);
    checkOutput({phase, " valid"}, 32'(vld), 32'h0);
    checkOutput({phase, " busy"}, 32'(busy), 32'h0);
    checkOutput({phase, " neg"}, 32'(neg), 32'h0);
    checkOutput({phase, " ovf"}, 32'(ovf), 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s bcd%0d", phase, i), obsBcd(i), 32'h0);
      checkOutput($sformatf("%s blank%0d", phase, i), obsBlank(i), 32'h0);
    end
  endtask

  initial begin
    logic [15:0] vals [8];
    bit          seen_valid;
    vals = '{16'd7, 16'd100, 16'd9999, 16'd10000, 16'h7FFF, 16'h8001, 16'd1000, 16'd99};

    repeat (2) @(negedge CLK);
    checkResetState("reset");
    RST_n = 1'b1;

    applyStimulus(16'hFFFF, 0);
    checkOutput("anchor_ffff_bcd", 32'(bcd_a), 32'h65535);
    checkOutput("anchor_ffff_blank", 32'(blank_a), 32'h0);

    applyStimulus(16'd12345, 10);
    checkOutput("anchor_sat_bcd", 32'(bcd_c), 32'h9999);
    checkOutput("anchor_trunc_bcd", 32'(bcd_d), 32'h2345);

    applyStimulus(16'h8000, 0);
    checkOutput("anchor_min_bcd", 32'(bcd_b), 32'h32768);
    checkOutput("anchor_min_neg", 32'(neg[1]), 32'h1);

    applyStimulus(16'hFFD6, 0);
    checkOutput("anchor_m42_bcd", 32'(bcd_b), 32'h00042);
    checkOutput("anchor_m42_blank", 32'(blank_b), 32'b11100);

    applyStimulus(16'h0000, 0);
    checkOutput("anchor_zero_blank", 32'(blank_a), 32'b11110);

    foreach (vals[i]) applyStimulus(vals[i], 0);
    repeat (4) applyStimulus(16'($urandom), 2);

    // Abort a conversion after five shift edges.
    @(negedge CLK);
    I_VALID = 1'b1;
    I_BIN   = 16'h4321;
    scoreboard.push_back(predict(16'h4321));
    @(negedge CLK);
    I_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    RST_n = 1'b0;
    #1;
    checkResetState("abort");
    void'(scoreboard.pop_front());
    @(negedge CLK);
    RST_n = 1'b1;
    seen_valid = 1'b0;
    repeat (25) begin
      @(negedge CLK);
      if (vld != 4'h0) seen_valid = 1'b1;
    end
    checkOutput("no_valid_after_abort", 32'(seen_valid), 32'h0);

    applyStimulus(16'h1234, 0);
    checkOutput("anchor_1234_bcd", 32'(bcd_a), 32'h04660);
    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
